// File: rtl/axis_uart_tx_s.sv
// AXI4-Stream slave that serializes each 32-bit word as four UART bytes, byte 0 (TDATA[7:0]) first.
// Optional AXIS_UART_TX_PARITY_EN inserts an even-parity bit after data bit 7 of every byte.

module axis_uart_tx_s #(
    parameter int BAUD_DIV = 868
) (
    input  logic        S_AXIS_ACLK,
    input  logic        S_AXIS_ARESET,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic [31:0] S_AXIS_TDATA,
    output logic        dout,
    output logic        busy
);

    localparam int            BW        = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

`ifdef AXIS_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [BW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [31:0]   shift_word;
    logic          handshake;
    logic          bit_end;
    logic [7:0]    next_byte;
    logic          dout_d;
    logic          busy_d;
    logic          tready_d;

    assign handshake = (state_q == IDLE) && S_AXIS_TVALID && S_AXIS_TREADY;
    assign bit_end   = (baud_cnt_q == BAUD_LAST);

    // Outputs are registered from next-state values so the line changes on the same edge as the state.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            state_q       <= IDLE;
            baud_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            shift_word    <= '0;
            dout          <= 1'b1;
            busy          <= 1'b0;
            S_AXIS_TREADY <= 1'b0;
        end else begin
            state_q       <= state_d;
            baud_cnt_q    <= baud_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            dout          <= dout_d;
            busy          <= busy_d;
            S_AXIS_TREADY <= tready_d;
            if (handshake) begin
                shift_word <= S_AXIS_TDATA;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d    = START;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d    = DATA;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
`ifdef AXIS_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
`ifdef AXIS_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    baud_cnt_d = '0;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = START;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        bit_cnt_d  = '0;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The latched word never shifts; the byte on the line is picked by byte_cnt.
    always_comb begin
        next_byte = shift_word[{byte_cnt_d, 3'b000} +: 8];
        dout_d    = 1'b1;
        case (state_d)
            START:   dout_d = 1'b0;
            DATA:    dout_d = next_byte[bit_cnt_d];
`ifdef AXIS_UART_TX_PARITY_EN
            PARITY:  dout_d = ^next_byte;
`endif
            default: dout_d = 1'b1;
        endcase
        tready_d = (state_d == IDLE);
        busy_d   = (state_d != IDLE);
    end

endmodule

// File: tb/tb_axis_uart_tx_s.sv
// Testbench for axis_uart_tx_s: queue-based line model checked every cycle plus directed literal checks.
// Build with AXIS_UART_TX_PARITY_EN defined to exercise the parity variant.

module tb_axis_uart_tx_s;

    localparam int BD = 4;
`ifdef AXIS_UART_TX_PARITY_EN
    localparam int FB       = 11;
    localparam int BUSY_LEN = 176;
`else
    localparam int FB       = 10;
    localparam int BUSY_LEN = 160;
`endif
    localparam int PAIR_LEN = 2 * BUSY_LEN + 12;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        tvalid = 1'b0;
    logic [31:0] tdata  = '0;
    logic        tready;
    logic        dout;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    logic rec_dout   [0:511];
    logic rec_busy   [0:511];
    logic rec_tready [0:511];
    logic frame0     [FB];

    axis_uart_tx_s #(.BAUD_DIV(BD)) dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (rst),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TREADY (tready),
        .S_AXIS_TDATA  (tdata),
        .dout          (dout),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Line model: an accepted word becomes a queue of per-cycle line levels that drains one per clock.
    bit   line_q[$];
    logic m_dout     = 1'b1;
    logic m_busy     = 1'b0;
    logic m_tready   = 1'b0;
    logic model_live = 1'b0;

    task automatic loadWord(input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            logic [7:0] byt;
            byt = w[b*8 +: 8];
            repeat (BD) line_q.push_back(1'b0);
            for (int j = 0; j < 8; j++) begin
                repeat (BD) line_q.push_back(byt[j]);
            end
`ifdef AXIS_UART_TX_PARITY_EN
            repeat (BD) line_q.push_back(^byt);
`endif
            repeat (BD) line_q.push_back(1'b1);
        end
    endtask

    always @(posedge clk) begin
        model_live <= 1'b1;
        if (rst) begin
            line_q.delete();
            m_dout   <= 1'b1;
            m_busy   <= 1'b0;
            m_tready <= 1'b0;
        end else begin
            if (m_tready && tvalid) begin
                loadWord(tdata);
            end
            if (line_q.size() > 0) begin
                m_dout   <= line_q.pop_front();
                m_busy   <= 1'b1;
                m_tready <= 1'b0;
            end else begin
                m_dout   <= 1'b1;
                m_busy   <= 1'b0;
                m_tready <= 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d);
        tvalid = v;
        tdata  = d;
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("cyc_dout",   32'(dout),   32'(m_dout));
            checkOutput("cyc_busy",   32'(busy),   32'(m_busy));
            checkOutput("cyc_tready", 32'(tready), 32'(m_tready));
        end
    end

    // Samples each bit near the middle of its BD-cycle period; base is the first start-bit sample.
    function automatic logic [31:0] decodeWord(input int base);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 8; j++) begin
                w[b*8 + j] = rec_dout[base + (b*FB + 1 + j)*BD + 2];
            end
        end
        return w;
    endfunction

    task automatic sendWord(input logic [31:0] w, output int busy_cycles, output int model_busy_cycles);
        applyStimulus(1'b1, w);
        busy_cycles       = 0;
        model_busy_cycles = 0;
        for (int i = 0; i < BUSY_LEN + 8; i++) begin
            @(negedge clk);
            if (i == 0) applyStimulus(1'b0, 32'h0);
            rec_dout[i]   = dout;
            rec_busy[i]   = busy;
            rec_tready[i] = tready;
            if (busy)   busy_cycles++;
            if (m_busy) model_busy_cycles++;
        end
    endtask

    task automatic runPair(input logic [31:0] w1, input logic [31:0] w2);
        int  hs1, hs2, n_hs, h1, b2, idle_cnt;
        bit  switched, dropped;
        hs1 = -1; hs2 = -1; n_hs = 0; switched = 0; dropped = 0;
        applyStimulus(1'b1, w1);
        if (tvalid && tready) begin
            hs1  = 0;
            n_hs = 1;
        end
        for (int i = 0; i < PAIR_LEN; i++) begin
            @(negedge clk);
            rec_dout[i]   = dout;
            rec_busy[i]   = busy;
            rec_tready[i] = tready;
            if (n_hs == 1 && !switched) begin
                applyStimulus(1'b1, w2);
                switched = 1;
            end else if (n_hs >= 2 && !dropped) begin
                applyStimulus(1'b0, 32'h0);
                dropped = 1;
            end
            if (tvalid && tready) begin
                if (n_hs == 0)      hs1 = i + 1;
                else if (n_hs == 1) hs2 = i + 1;
                n_hs++;
            end
        end
        if (!dropped) applyStimulus(1'b0, 32'h0);
        h1 = (hs1 >= 0 && hs1 < 64) ? hs1 : 0;
        b2 = (hs2 >= 2 && hs2 + BUSY_LEN <= PAIR_LEN) ? hs2 : BUSY_LEN + 1;
        checkOutput("pair_hs_gap", 32'(hs2 - hs1), 32'(BUSY_LEN + 1));
        idle_cnt = 0;
        for (int i = h1; i < b2; i++) begin
            if (!rec_busy[i]) idle_cnt++;
        end
        checkOutput("pair_idle_cycles", 32'(idle_cnt), 32'd1);
        checkOutput("pair_idle_dout", 32'(rec_dout[b2-1]), 32'd1);
        checkOutput("pair_start2_dout", 32'(rec_dout[b2]), 32'd0);
        checkOutput("pair_word1", decodeWord(h1), w1);
        checkOutput("pair_word2", decodeWord(b2), w2);
    endtask

    initial begin
        int ones, bc, mbc;
`ifdef AXIS_UART_TX_PARITY_EN
        frame0 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        frame0 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0);
        repeat (3) @(negedge clk);
        checkOutput("rst_dout",   32'(dout),   32'd1);
        checkOutput("rst_busy",   32'(busy),   32'd0);
        checkOutput("rst_tready", 32'(tready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("release_tready", 32'(tready), 32'd1);
        checkOutput("release_busy",   32'(busy),   32'd0);
        ones = 0;
        repeat (200) begin
            @(negedge clk);
            if (dout && !busy) ones++;
        end
        checkOutput("idle_200", 32'(ones), 32'd200);

        $display("[TB] single word 0x44332211");
        sendWord(32'h44332211, bc, mbc);
        for (int k = 0; k < FB; k++) begin
            for (int j = 0; j < BD; j++) begin
                checkOutput("first_frame", 32'(rec_dout[k*BD + j]), 32'(frame0[k]));
            end
        end
        checkOutput("busy_len",       32'(bc),  32'(BUSY_LEN));
        checkOutput("model_busy_len", 32'(mbc), 32'(BUSY_LEN));
        checkOutput("tready_before_end", 32'(rec_tready[BUSY_LEN-1]), 32'd0);
        checkOutput("tready_return",     32'(rec_tready[BUSY_LEN]),   32'd1);
        checkOutput("busy_drop",         32'(rec_busy[BUSY_LEN]),     32'd0);
        checkOutput("single_bytes", decodeWord(0), 32'h44332211);

        $display("[TB] back-to-back words");
        runPair(32'hA5A5A5A5, 32'h0000FF00);

        $display("[TB] data hold while busy");
        runPair(32'h12345678, 32'hDEADBEEF);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 32'h0);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0);
        repeat (49) @(negedge clk);
        checkOutput("midframe_dout", 32'(dout), 32'd0);
        checkOutput("midframe_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_dout",   32'(dout),   32'd1);
        checkOutput("abort_busy",   32'(busy),   32'd0);
        checkOutput("abort_tready", 32'(tready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_release_tready", 32'(tready), 32'd1);
        sendWord(32'h000000C3, bc, mbc);
        checkOutput("recover_bytes", decodeWord(0), 32'h000000C3);
        checkOutput("recover_busy_len", 32'(bc), 32'(BUSY_LEN));

`ifdef AXIS_UART_TX_PARITY_EN
        $display("[TB] parity word 0x00000301");
        sendWord(32'h00000301, bc, mbc);
        checkOutput("parity_busy_len", 32'(bc), 32'd176);
        checkOutput("parity_bytes", decodeWord(0), 32'h00000301);
        checkOutput("parity_b0", 32'(rec_dout[(0*FB + 9)*BD + 2]), 32'd1);
        checkOutput("parity_b1", 32'(rec_dout[(1*FB + 9)*BD + 2]), 32'd0);
        checkOutput("parity_b2", 32'(rec_dout[(2*FB + 9)*BD + 2]), 32'd0);
        checkOutput("parity_b3", 32'(rec_dout[(3*FB + 9)*BD + 2]), 32'd0);
`endif

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
